instr_issue: RTL and testbench

Buffers 8-bit host instructions in a small FIFO and issues them one at a time to the matrix controller FSM's `host_instruction` input. It holds each instruction stable for the whole operation, which is needed because the controller reads the DD/AA fields combinationally. It sits between the host bus and the controller, and its only feedback from the controller is `busy`.

---
 rtl/mpu_pkg.sv | 23 ++
 rtl/instr_issue_if.sv | 27 ++
 rtl/instr_fifo.sv | 60 ++++++
 rtl/instr_issue.sv | 92 +++++++++
 tb/tb_instr_issue.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mpu_pkg.sv
// Shared matrix-unit definitions: instruction width, opcode constants and
// the NOP class test used by the host-side instruction path.
package mpu_pkg;

    localparam int IW = 8;

    localparam logic [3:0] OP_LOAD   = 4'b0100;
    localparam logic [3:0] OP_UNLOAD = 4'b0110;
    localparam logic [3:0] OP_COPY   = 4'b0101;
    localparam logic [3:0] OP_CLEAR  = 4'b0111;
    localparam logic [3:0] OP_ADD    = 4'b1100;
    localparam logic [3:0] OP_SHIFT  = 4'b1101;
    localparam logic [3:0] OP_SUB    = 4'b1110;
    localparam logic [3:0] OP_MULT   = 4'b1111;

    // Instructions whose OP[3:2] bits are zero belong to the NOP class
    localparam logic [3:0] NOP_MASK = 4'b1100;

    function automatic logic is_nop(input logic [IW-1:0] instr);
        return (instr[3:0] & NOP_MASK) == 4'b0000;
    endfunction

endpackage

// File: rtl/instr_issue_if.sv
// Host offer/accept handshake plus the controller-facing instruction and
// busy lines. The host/controller side uses master, the issuer uses slave.
interface instr_issue_if #(
    parameter int IW = 8
);
    logic          host_valid;
    logic [IW-1:0] host_instr;
    logic          host_ready;
    logic          fsm_busy;
    logic [IW-1:0] host_instruction;

    modport master (
        output host_valid,
        output host_instr,
        output fsm_busy,
        input  host_ready,
        input  host_instruction
    );

    modport slave (
        input  host_valid,
        input  host_instr,
        input  fsm_busy,
        output host_ready,
        output host_instruction
    );
endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO with occupancy count and full/empty flags. Pointers wrap
// modulo DEPTH; a push and pop on the same edge leave the count unchanged.
module instr_fifo #(
    parameter int DEPTH = 8,
    parameter int IW    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [IW-1:0]            din,
    output logic [IW-1:0]            dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [IW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage array: written on an accepted push, not reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_issue.sv
// Queues host instructions and presents them one at a time to the matrix
// controller, holding each stable while the controller executes it.
module instr_issue
    import mpu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    instr_issue_if.slave           bus,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   issue_idle
);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [1:0] S_EMPTY   = 2'b00;
    localparam logic [1:0] S_PRESENT = 2'b01;
    localparam logic [1:0] S_EXEC    = 2'b10;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [IW-1:0] head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    assign bus.host_ready = ~fifo_full;
    assign push           = bus.host_valid & ~fifo_full & ~is_nop(bus.host_instr);
    assign pop            = (state == S_EXEC) & ~bus.fsm_busy;
    assign issue_idle     = (state == S_EMPTY) & fifo_empty;

    instr_fifo #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.host_instr),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Issuer next-state
    always_comb begin
        state_nx = state;
        case (state)
            S_EMPTY: begin
                if (!fifo_empty) begin
                    state_nx = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (!bus.fsm_busy) begin
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                // An entry pushed on the completion edge still counts as
                // remaining, so the issuer goes straight back to PRESENT.
                if (!bus.fsm_busy) begin
                    state_nx = ((fifo_count > CW'(1)) || push) ? S_PRESENT : S_EMPTY;
                end
            end
            default: state_nx = S_EMPTY;
        endcase
    end

    // Issuer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Instruction mux: drop to zero once the controller has gone idle
    always_comb begin
        bus.host_instruction = '0;
        case (state)
            S_PRESENT: bus.host_instruction = head;
            S_EXEC:    bus.host_instruction = bus.fsm_busy ? head : '0;
            default:   bus.host_instruction = '0;
        endcase
    end

endmodule

// File: tb/tb_instr_issue.sv
// Bench for instr_issue: a small controller model consumes issued
// instructions and a queue of expected instructions checks issue order.
module tb_instr_issue;
    import mpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] fifo_count;
    logic       issue_idle;

    instr_issue_if #(.IW(8)) ifc ();

    instr_issue #(.DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (ifc),
        .fifo_count (fifo_count),
        .issue_idle (issue_idle)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_errors  = 0;
    int n_pushed  = 0;
    int n_samples = 0;
    int n_flushed = 0;
    logic [7:0] sbq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Controller model: samples a non-zero instruction while idle, then
    // stays busy for an opcode-dependent number of cycles.
    logic busy;
    logic stall;
    int   cnt;
    int   offset;
    int   last_load_off;
    logic [3:0] cur_op;

    function automatic int dur(input logic [3:0] op);
        case (op)
            OP_LOAD, OP_UNLOAD: return 64;
            OP_SUB:             return 3;
            OP_CLEAR:           return 2;
            default:            return 1;
        endcase
    endfunction

    assign ifc.fsm_busy = busy;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy   <= 1'b0;
            cnt    <= 0;
            offset <= 0;
        end else if (stall) begin
            busy <= 1'b1;
            cnt  <= 1;
        end else if (busy) begin
            offset <= offset + 1;
            if (cnt <= 1) begin
                busy <= 1'b0;
                if (cur_op == OP_LOAD) last_load_off <= offset + 1;
            end else begin
                cnt <= cnt - 1;
            end
        end else if (ifc.host_instruction != 8'h00) begin
            busy   <= 1'b1;
            cnt    <= dur(ifc.host_instruction[3:0]);
            offset <= 0;
            cur_op <= ifc.host_instruction[3:0];
        end
    end

    // Monitor: scoreboard compare on each controller sample, gap tracking
    logic       gap_en = 1'b0;
    logic       gap_armed;
    int         zero_run;
    int         n_gaps = 0;
    logic [7:0] last_nz;

    always @(negedge clk) begin
        if (reset && !busy && ifc.host_instruction != 8'h00) begin
            n_samples++;
            if (sbq.size() == 0)
                check("sb_underflow", 32'(ifc.host_instruction), 32'h0);
            else
                check("issue_order", 32'(ifc.host_instruction), 32'(sbq.pop_front()));
        end
        if (gap_en) begin
            if (ifc.host_instruction != 8'h00) begin
                if (gap_armed && (zero_run != 0 || ifc.host_instruction != last_nz)) begin
                    check("op_gap", 32'(zero_run), 32'd1);
                    n_gaps++;
                end
                gap_armed = 1'b1;
                zero_run  = 0;
                last_nz   = ifc.host_instruction;
            end else begin
                zero_run++;
            end
        end
    end

    task automatic push_one(input logic [7:0] v, output bit ok);
        @(negedge clk);
        ifc.host_valid = 1'b1;
        ifc.host_instr = v;
        ok = ifc.host_ready;
        @(posedge clk);
        #1 ifc.host_valid = 1'b0;
        if (ok && v[3:2] != 2'b00) begin
            sbq.push_back(v);
            n_pushed++;
        end
    endtask

    task automatic wait_drain(input string tag, input int max_cycles);
        bit done = 1'b0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            @(negedge clk);
            if (issue_idle && !busy && sbq.size() == 0) done = 1'b1;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    bit ok;
    int acc;
    int s0;

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        ifc.host_valid = 1'b0;
        ifc.host_instr = 8'h00;
        last_load_off = 0;
        cur_op = 4'h0;

        // Reset values
        #3;
        check("rst_instr", 32'(ifc.host_instruction), 32'h0);
        check("rst_ready", 32'(ifc.host_ready), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_idle",  32'(issue_idle), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single ADD, controller busy one cycle
        push_one(8'b01_10_1100, ok);
        @(negedge clk);
        check("add_c0_instr", 32'(ifc.host_instruction), 32'h0);
        check("add_c0_count", 32'(fifo_count), 32'd1);
        @(negedge clk);
        check("add_c1_head", 32'(ifc.host_instruction), 32'h6C);
        @(negedge clk);
        check("add_c2_busy", 32'(busy), 32'd1);
        check("add_c2_hold", 32'(ifc.host_instruction), 32'h6C);
        @(negedge clk);
        check("add_c3_bubble", 32'(ifc.host_instruction), 32'h0);
        @(negedge clk);
        check("add_c4_idle", 32'(issue_idle), 32'd1);
        check("add_c4_count", 32'(fifo_count), 32'd0);

        // NOP filtering
        s0 = n_samples;
        push_one(8'hF3, ok);
        check("nop_handshake", 32'(ok), 32'd1);
        @(negedge clk);
        check("nop_count", 32'(fifo_count), 32'd0);
        repeat (4) @(negedge clk);
        check("nop_no_issue", 32'(n_samples - s0), 32'd0);
        check("nop_idle", 32'(issue_idle), 32'd1);

        // Back-to-back LOAD, SUB, CLEAR
        s0 = n_samples;
        gap_armed = 1'b0;
        zero_run  = 0;
        last_nz   = 8'h00;
        gap_en    = 1'b1;
        push_one({2'b00, 2'b01, OP_LOAD}, ok);
        push_one({2'b01, 2'b10, OP_SUB}, ok);
        push_one({2'b10, 2'b11, OP_CLEAR}, ok);
        wait_drain("b2b_drain", 300);
        gap_en = 1'b0;
        check("b2b_samples", 32'(n_samples - s0), 32'd3);
        check("b2b_gaps", 32'(n_gaps), 32'd2);
        check("load_offset", 32'(last_load_off), 32'd64);

        // Push coinciding with the EXEC completion pop
        push_one(8'b00_01_1100, ok);
        repeat (3) @(posedge clk);
        #2;
        check("pp_bubble", 32'(ifc.host_instruction), 32'h0);
        check("pp_count_before", 32'(fifo_count), 32'd1);
        push_one(8'b11_00_1101, ok);
        @(negedge clk);
        check("pp_count_after", 32'(fifo_count), 32'd1);
        check("pp_new_head", 32'(ifc.host_instruction), 32'hCD);
        wait_drain("pp_drain", 50);

        // Fill while the controller is stalled busy
        @(negedge clk);
        stall = 1'b1;
        repeat (2) @(posedge clk);
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            logic [3:0] b;
            b = 4'(i);
            push_one({b[1:0], b[3:2], OP_ADD}, ok);
            if (ok) acc++;
        end
        @(negedge clk);
        check("fill_accepted", 32'(acc), 32'd8);
        check("fill_count", 32'(fifo_count), 32'd8);
        check("fill_ready", 32'(ifc.host_ready), 32'd0);
        stall = 1'b0;
        wait_drain("fill_drain", 100);

        // Reset during a LOAD with three entries behind it
        push_one({2'b11, 2'b00, OP_LOAD}, ok);
        push_one({2'b00, 2'b00, OP_ADD}, ok);
        push_one({2'b01, 2'b01, OP_SUB}, ok);
        push_one({2'b10, 2'b10, OP_CLEAR}, ok);
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_count", 32'(fifo_count), 32'd4);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_instr", 32'(ifc.host_instruction), 32'h0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_ready", 32'(ifc.host_ready), 32'd1);
        check("mid_rst_idle",  32'(issue_idle), 32'd1);
        n_flushed = sbq.size();
        sbq.delete();
        @(negedge clk);
        #1 reset = 1'b1;
        s0 = n_samples;
        repeat (4) @(negedge clk);
        check("post_rst_quiet", 32'(n_samples - s0), 32'd0);
        check("post_rst_idle", 32'(issue_idle), 32'd1);

        check("sb_leftover", 32'(sbq.size()), 32'd0);
        check("sample_total", 32'(n_samples + n_flushed), 32'(n_pushed));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
